usb_tx_controller: RTL
======================

Name: usb_tx_controller

Overview:
- Host-bound transmit path for the FT245-style USB FIFO. It is the write-direction companion to usb_controller, which only reads from the FIFO.
- Buffers bytes from on-chip sources in a small FIFO and writes them to the FT245 with the txe_n/wr_n strobe protocol.
- Shares the bidirectional data bus with usb_controller through a bus_req/bus_grant handshake.

Parameters:
- FIFO_DEPTH, 16: transmit buffer depth in bytes. Must be a power of 2, at least 2.
- SETUP_CYCLES, 2: clocks that data is driven before wr_n falls. Must be at least 1.
- PULSE_CYCLES, 3: clocks that wr_n is held low. Must be at least 1.
- RECOVERY_CYCLES, 2: clocks with data_out_enable low after a byte, before the next byte starts. Must be at least 1.

Ports:
- clk, in, 1: system clock, 50 MHz.
- reset, in, 1: synchronous, active-high reset.
- tx_data, in, 8: byte to transmit.
- tx_valid, in, 1: tx_data is valid.
- tx_ready, out, 1: FIFO can accept a byte. A push occurs when tx_valid && tx_ready.
- txe_n_raw, in, 1: FT245 TXE#, asynchronous. Low means there is room in the device buffer.
- bus_grant, in, 1: arbiter grants the data bus to this block.
- bus_req, out, 1: request for the shared data bus.
- data_bus_out, out, 8: byte driven to the FT245.
- data_out_enable, out, 1: tristate enable for the data bus.
- wr_n, out, 1: FT245 WR strobe, active low.
- fifo_count, out, log2(FIFO_DEPTH)+1: bytes currently buffered.
- state_out, out, 3: current FSM state encoding, for debug.

Behaviour:
- All state is registered on the clk rising edge. Reset is synchronous and active-high, as already decided.
- Reset values:
  - wr_n=1, data_out_enable=0, bus_req=0, data_bus_out=8'h00.
  - FIFO empty, fifo_count=0, tx_ready=1.
  - state=IDLE, all timing counters 0.
  - A push presented while reset is high is discarded.
- txe_n_raw passes through a 2-flop synchronizer to give txe_sync. Its reset value is 1 (device full).
- FIFO:
  - tx_ready = (fifo_count != FIFO_DEPTH), derived from registered state.
  - The pop happens on the STROBE→HOLD transition.
  - A push and a pop in the same cycle leave fifo_count unchanged.
  - When full, tx_ready=0, so no push occurs.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- FSM states and transitions (state_out encoding: IDLE=0, REQ=1, SETUP=2, STROBE=3, HOLD=4, RECOVER=5):
  - IDLE: bus_req=0. Go to REQ when fifo_count != 0.
  - REQ: bus_req=1. Go to SETUP when bus_grant && !txe_sync; otherwise wait here indefinitely.
  - SETUP: data_out_enable=1, data_bus_out = FIFO head, wr_n=1. Lasts SETUP_CYCLES clocks, then go to STROBE.
  - STROBE: wr_n=0 for PULSE_CYCLES clocks, then go to HOLD and pop the FIFO. Once STROBE is entered the byte always completes, even if txe_n or bus_grant changes.
  - HOLD: wr_n=1, data still driven, 1 clock, then go to RECOVER.
  - RECOVER: data_out_enable=0. Lasts RECOVERY_CYCLES clocks, then:
    - go to SETUP if the FIFO is non-empty and bus_grant && !txe_sync;
    - go to REQ if the FIFO is non-empty but that condition is false;
    - go to IDLE if the FIFO is empty.
- bus_req stays high from REQ through RECOVER. It drops only in IDLE or on reset.
- data_out_enable is high only in SETUP, STROBE and HOLD. data_bus_out is stable through that whole window.
- Latency: with bus_grant=1 and txe_sync already 0, wr_n falls on clock edge 2+SETUP_CYCLES counted after the push edge.
- Back-to-back byte period = SETUP_CYCLES + PULSE_CYCLES + 1 + RECOVERY_CYCLES clocks.
- A reset mid-transfer aborts the byte immediately. On the next cycle wr_n=1 and data_out_enable=0, and buffered data is lost.

Optional Feature:
- Macro: USB_TX_STATUS_FRAME_EN.
- When defined, two extra inputs are added:
  - status_req, 1 bit: pulse requesting a status frame.
  - panel_switches, 16 bits: switch state to report.
- Behaviour when defined:
  - A status_req pulse captures panel_switches and sets a pending flag.
  - At the next decision point (IDLE, REQ, or the exit from RECOVER), the frame bytes 0xA5, sw[15:8], sw[7:0] are sent ahead of FIFO data. They use the same timing and do not occupy the FIFO.
  - A status_req arriving while a frame is pending or in progress is ignored.
- When undefined, the ports and logic are absent.

Test Plan:
1. Assert reset for 3 cycles while tx_valid=1 → wr_n=1, data_out_enable=0, bus_req=0, tx_ready=1, fifo_count=0. No push is recorded.
2. Set bus_grant=1, txe_n_raw=0, defaults, then push 0x23 → wr_n falls on edge 4 after the push and stays low exactly 3 cycles. data_bus_out=0x23 throughout the data_out_enable window. fifo_count returns to 0.
3. Set txe_n_raw=1 and push 0x00..0x10 → tx_ready=0 after 16 pushes, fifo_count=16, 0x10 is refused. Drop txe_n_raw → 16 strobes in order 0x00..0x0F, each period 8 cycles.
4. Raise txe_n_raw during the STROBE of 0x55 with 0x66 queued → 0x55 completes. FSM waits in REQ with bus_req=1 and data_out_enable=0. 0x66 is sent only after 2 cycles of txe_n_raw=0.
5. Hold bus_grant=0 with 0x12 queued → bus_req=1 and data_out_enable stays 0 indefinitely. Assert grant → byte goes out. Also assert reset mid-STROBE → next cycle wr_n=1, data_out_enable=0, fifo_count=0.
6. With USB_TX_STATUS_FRAME_EN defined, panel_switches=16'hFDEC, and status_req pulsed while 0x01 is queued → bytes sent in order 0xA5, 0xFD, 0xEC, 0x01.

Source files
------------

// File: rtl/usb_tx_if.sv
// Byte-push handshake plus FT245 write-side bus signals for usb_tx_controller.
// master = surrounding system/arbiter/device, slave = the transmit controller.
interface usb_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       txe_n_raw;
  logic       bus_grant;
  logic       bus_req;
  logic [7:0] data_bus_out;
  logic       data_out_enable;
  logic       wr_n;

  modport master (
    output tx_data, tx_valid, txe_n_raw, bus_grant,
    input  tx_ready, bus_req, data_bus_out, data_out_enable, wr_n
  );

  modport slave (
    input  tx_data, tx_valid, txe_n_raw, bus_grant,
    output tx_ready, bus_req, data_bus_out, data_out_enable, wr_n
  );
endinterface

// File: rtl/usb_tx_controller.sv
// FT245 host-bound transmit path: byte FIFO, TXE# synchronizer, shared-bus request and WR# strobe FSM.
// Optional status frame (0xA5, sw[15:8], sw[7:0]) enabled by defining USB_TX_STATUS_FRAME_EN.
module usb_tx_controller #(
  parameter int FIFO_DEPTH      = 16,
  parameter int SETUP_CYCLES    = 2,
  parameter int PULSE_CYCLES    = 3,
  parameter int RECOVERY_CYCLES = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  usb_tx_if.slave                     bus,
`ifdef USB_TX_STATUS_FRAME_EN
  input  logic                        status_req,
  input  logic [15:0]                 panel_switches,
`endif
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic [2:0]                  state_out
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    SETUP   = 3'd2,
    STROBE  = 3'd3,
    HOLD    = 3'd4,
    RECOVER = 3'd5
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic          txe_meta, txe_sync;
  logic [7:0]    dout;
  logic          push, pop, go, strobe_done, have_work, load_byte;
  logic [7:0]    next_byte;

  assign push        = bus.tx_valid && bus.tx_ready;
  assign go          = bus.bus_grant && !txe_sync;
  assign strobe_done = (state == STROBE) && (cnt == CW'(PULSE_CYCLES - 1));

`ifdef USB_TX_STATUS_FRAME_EN
  logic        pend;
  logic        cur_frame;
  logic [15:0] sw;
  logic [1:0]  fidx;

  function automatic logic [7:0] frame_byte(input logic [1:0] idx, input logic [15:0] s);
    case (idx)
      2'd0:    frame_byte = 8'hA5;
      2'd1:    frame_byte = s[15:8];
      default: frame_byte = s[7:0];
    endcase
  endfunction

  // A pending frame takes priority over buffered bytes at every byte-start decision.
  assign have_work = (count != '0) || pend;
  assign next_byte = pend ? frame_byte(fidx, sw) : mem[rd_ptr];
  assign pop       = strobe_done && !cur_frame;

  always_ff @(posedge clk) begin
    if (reset) begin
      pend      <= 1'b0;
      cur_frame <= 1'b0;
      sw        <= '0;
      fidx      <= '0;
    end else begin
      if (status_req && !pend) begin
        pend <= 1'b1;
        sw   <= panel_switches;
      end
      if (load_byte) cur_frame <= pend;
      if (strobe_done && cur_frame) begin
        if (fidx == 2'd2) begin
          fidx <= '0;
          pend <= 1'b0;
        end else begin
          fidx <= fidx + 2'd1;
        end
      end
    end
  end
`else
  assign have_work = (count != '0);
  assign next_byte = mem[rd_ptr];
  assign pop       = strobe_done;
`endif

  always_comb begin
    state_nx  = state;
    load_byte = 1'b0;
    unique case (state)
      IDLE:    if (have_work) state_nx = REQ;
      REQ: begin
        if (go) begin
          state_nx  = SETUP;
          load_byte = 1'b1;
        end
      end
      SETUP:   if (cnt == CW'(SETUP_CYCLES - 1)) state_nx = STROBE;
      STROBE:  if (strobe_done) state_nx = HOLD;
      HOLD:    state_nx = RECOVER;
      RECOVER: begin
        if (cnt == CW'(RECOVERY_CYCLES - 1)) begin
          if (!have_work) begin
            state_nx = IDLE;
          end else if (go) begin
            state_nx  = SETUP;
            load_byte = 1'b1;
          end else begin
            state_nx = REQ;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      txe_meta <= 1'b1;
      txe_sync <= 1'b1;
      dout     <= 8'h00;
    end else begin
      txe_meta <= bus.txe_n_raw;
      txe_sync <= txe_meta;
      state    <= state_nx;
      cnt      <= (state_nx != state) ? '0 : cnt + 1'b1;
      // Data is latched at byte start so it stays stable through HOLD after the pop.
      if (load_byte) dout <= next_byte;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) mem[wr_ptr] <= bus.tx_data;
  end

  assign bus.tx_ready        = (count != (AW + 1)'(FIFO_DEPTH));
  assign bus.bus_req         = (state != IDLE);
  assign bus.data_out_enable = (state == SETUP) || (state == STROBE) || (state == HOLD);
  assign bus.wr_n            = (state != STROBE);
  assign bus.data_bus_out    = dout;
  assign fifo_count          = count;
  assign state_out           = state;

endmodule
